// File: rtl/hsem_task_queue.sv
// hsem_task_queue: NUM_CH independent task FIFOs, each DEPTH entries of DATA_W bits.
// AHB writes push into the channel selected by ch_sel. Each core pops its own channel.
// Per-channel head word, valid, occupancy, sticky overflow and a new-task pulse are exported.
module hsem_task_queue #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int CH_W  = $clog2(NUM_CH),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                     hclk,
  input  logic                     hreset,
  input  logic                     wr_en,
  input  logic                     task_en,
  input  logic [CH_W-1:0]          ch_sel,
  input  logic [DATA_W-1:0]        ihwdata,
  input  logic [NUM_CH-1:0]        pop,
  input  logic [NUM_CH-1:0]        clr,
  output logic [NUM_CH*DATA_W-1:0] tsk_stat,
  output logic [NUM_CH-1:0]        tsk_vld,
  output logic [NUM_CH*CNT_W-1:0]  tsk_cnt,
  output logic [NUM_CH-1:0]        ovf,
  output logic [NUM_CH-1:0]        irq
);

  logic push;
  assign push = task_en & wr_en;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_W-1:0] mem_reg [DEPTH];
      logic [PTR_W-1:0]  wp_reg;
      logic [PTR_W-1:0]  rp_reg;
      logic [CNT_W-1:0]  cnt_reg;
      logic              ovf_reg;
      logic              vld_q_reg;
      logic              push_hit;
      logic              pop_ok;
      logic              full;
      logic              wr_ok;
      logic              drop;

      // A pop on an empty channel is ignored. A full channel still takes a push
      // when a pop frees a slot in the same cycle.
      assign push_hit = push && (ch_sel == CH_W'(gi));
      assign pop_ok   = pop[gi] && (cnt_reg != '0);
      assign full     = (cnt_reg == CNT_W'(DEPTH));
      assign wr_ok    = push_hit && (!full || pop_ok);
      assign drop     = push_hit && full && !pop_ok;

      // Storage array: no reset, because contents are masked whenever cnt is 0.
      always_ff @(posedge hclk) begin
        if (wr_ok && !clr[gi]) begin
          mem_reg[wp_reg] <= ihwdata;
        end
      end

      // Pointer, count and sticky flag update. Flush overrides push and pop.
      always_ff @(posedge hclk) begin
        if (hreset) begin
          wp_reg    <= '0;
          rp_reg    <= '0;
          cnt_reg   <= '0;
          ovf_reg   <= 1'b0;
          vld_q_reg <= 1'b0;
        end else begin
          vld_q_reg <= tsk_vld[gi];
          if (clr[gi]) begin
            wp_reg  <= '0;
            rp_reg  <= '0;
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
          end else begin
            if (wr_ok) begin
              wp_reg <= wp_reg + PTR_W'(1);
            end
            if (pop_ok) begin
              rp_reg <= rp_reg + PTR_W'(1);
            end
            if (wr_ok && !pop_ok) begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end else if (pop_ok && !wr_ok) begin
              cnt_reg <= cnt_reg - CNT_W'(1);
            end
            if (drop) begin
              ovf_reg <= 1'b1;
            end
          end
        end
      end

      // Outputs depend only on registered state.
      assign tsk_vld[gi]                     = (cnt_reg != '0);
      assign tsk_stat[gi*DATA_W +: DATA_W]   = tsk_vld[gi] ? mem_reg[rp_reg] : '0;
      assign tsk_cnt[gi*CNT_W +: CNT_W]      = cnt_reg;
      assign ovf[gi]                         = ovf_reg;
      assign irq[gi]                         = tsk_vld[gi] & ~vld_q_reg;
    end
  endgenerate

endmodule

// File: tb/tb_hsem_task_queue.sv
// tb_hsem_task_queue: directed stimulus, queue-based reference model and
// per-cycle output comparison, plus literal expectations at key points.
module tb_hsem_task_queue;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int DEP = 4;
  localparam int CW  = 3;

  logic              hclk;
  logic              hreset;
  logic              wr_en;
  logic              task_en;
  logic [1:0]        ch_sel;
  logic [DW-1:0]     ihwdata;
  logic [NCH-1:0]    pop;
  logic [NCH-1:0]    clr;
  logic [NCH*DW-1:0] tsk_stat;
  logic [NCH-1:0]    tsk_vld;
  logic [NCH*CW-1:0] tsk_cnt;
  logic [NCH-1:0]    ovf;
  logic [NCH-1:0]    irq;

  hsem_task_queue #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP)) dut (
    .hclk(hclk), .hreset(hreset), .wr_en(wr_en), .task_en(task_en),
    .ch_sel(ch_sel), .ihwdata(ihwdata), .pop(pop), .clr(clr),
    .tsk_stat(tsk_stat), .tsk_vld(tsk_vld), .tsk_cnt(tsk_cnt),
    .ovf(ovf), .irq(irq)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Reference model: one queue per channel holding the pending words in order.
  logic [DW-1:0]  mq [NCH][$];
  logic [NCH-1:0] m_ovf;
  logic [NCH-1:0] m_prev_vld;

  int  n_chk;
  int  n_fail;
  bit  chk_en;
  bit  irq_cnt_en;
  int  irq_cnt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] stat(input int ch);
    return tsk_stat[ch*DW +: DW];
  endfunction

  function automatic logic [CW-1:0] cnt(input int ch);
    return tsk_cnt[ch*CW +: CW];
  endfunction

  // Apply one cycle of stimulus, advance the model at the edge, return on the falling edge.
  task automatic cycle(input bit p, input int ch, input logic [DW-1:0] d,
                       input logic [NCH-1:0] pp, input logic [NCH-1:0] cl, input bit r);
    wr_en   = p;
    task_en = p;
    ch_sel  = 2'(ch);
    ihwdata = d;
    pop     = pp;
    clr     = cl;
    hreset  = r;
    @(posedge hclk);
    for (int i = 0; i < NCH; i++) begin
      if (r) begin
        mq[i].delete();
        m_ovf[i]      = 1'b0;
        m_prev_vld[i] = 1'b0;
      end else begin
        m_prev_vld[i] = (mq[i].size() != 0);
        if (cl[i]) begin
          mq[i].delete();
          m_ovf[i] = 1'b0;
        end else begin
          if (pp[i] && mq[i].size() != 0) void'(mq[i].pop_front());
          if (p && ch == i) begin
            if (mq[i].size() < DEP) mq[i].push_back(d);
            else m_ovf[i] = 1'b1;
          end
        end
      end
    end
    @(negedge hclk);
    if (irq_cnt_en) irq_cnt += int'(irq[0]);
    $display("cyc t=%0t push=%0b ch=%0d data=%h pop=%b clr=%b rst=%0b | vld=%b cnt=%h ovf=%b irq=%b",
             $time, p, ch, d, pp, cl, r, tsk_vld, tsk_cnt, ovf, irq);
  endtask

  task automatic push_w(input int ch, input logic [DW-1:0] d);
    cycle(1'b1, ch, d, '0, '0, 1'b0);
  endtask

  task automatic pop_m(input logic [NCH-1:0] m);
    cycle(1'b0, 0, '0, m, '0, 1'b0);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge hclk) begin
    if (chk_en) begin
      logic [NCH*DW-1:0] es;
      logic [NCH*CW-1:0] ec;
      logic [NCH-1:0]    ev;
      logic [NCH-1:0]    ei;
      for (int i = 0; i < NCH; i++) begin
        es[i*DW +: DW] = (mq[i].size() != 0) ? mq[i][0] : '0;
        ec[i*CW +: CW] = CW'(mq[i].size());
        ev[i]          = (mq[i].size() != 0);
        ei[i]          = ev[i] & ~m_prev_vld[i];
      end
      chk("model_stat", 128'(tsk_stat), 128'(es));
      chk("model_cnt",  128'(tsk_cnt),  128'(ec));
      chk("model_vld",  128'(tsk_vld),  128'(ev));
      chk("model_ovf",  128'(ovf),      128'(m_ovf));
      chk("model_irq",  128'(irq),      128'(ei));
    end
  end

  initial begin
    n_chk = 0; n_fail = 0; chk_en = 0; irq_cnt_en = 0; irq_cnt = 0;
    m_ovf = '0; m_prev_vld = '0;
    hreset = 1'b1; wr_en = 0; task_en = 0; ch_sel = 0; ihwdata = 0; pop = 0; clr = 0;
    @(negedge hclk);
    cycle(1'b0, 0, '0, '0, '0, 1'b1);
    chk_en = 1;
    chk("rst_stat", 128'(tsk_stat), 128'd0);
    chk("rst_vld",  128'(tsk_vld),  128'd0);
    chk("rst_irq",  128'(irq),      128'd0);

    // Single push to channel 2.
    push_w(2, 32'hA5A5_0001);
    chk("p2_stat", 128'(stat(2)), 128'h A5A5_0001);
    chk("p2_vld",  128'(tsk_vld), 128'b0100);
    chk("p2_cnt",  128'(cnt(2)),  128'd1);
    chk("p2_irq",  128'(irq),     128'b0100);
    pop_m('0);
    chk("p2_irq_off", 128'(irq), 128'd0);

    // Overflow on channel 0, then drain in order.
    for (int k = 1; k <= 5; k++) push_w(0, DW'(k));
    chk("ovf0_cnt", 128'(cnt(0)), 128'd4);
    chk("ovf0_flag", 128'(ovf[0]), 128'd1);
    for (int k = 1; k <= 4; k++) begin
      chk("drain0_head", 128'(stat(0)), 128'(k));
      pop_m(4'b0001);
    end
    chk("drain0_stat", 128'(stat(0)), 128'd0);
    chk("drain0_vld",  128'(tsk_vld[0]), 128'd0);
    chk("drain0_ovf",  128'(ovf[0]), 128'd1);

    // Full channel 1 accepts a push when popped in the same cycle.
    for (int k = 0; k < 4; k++) push_w(1, DW'(32'h11 + k));
    cycle(1'b1, 1, 32'h9, 4'b0010, '0, 1'b0);
    chk("fullpp_cnt", 128'(cnt(1)), 128'd4);
    chk("fullpp_ovf", 128'(ovf[1]), 128'd0);
    for (int k = 0; k < 4; k++) begin
      logic [DW-1:0] exp_h;
      exp_h = (k < 3) ? DW'(32'h12 + k) : 32'h9;
      chk("fullpp_head", 128'(stat(1)), 128'(exp_h));
      pop_m(4'b0010);
    end

    // Empty channel 3: push wins, pop is ignored.
    cycle(1'b1, 3, 32'h33, 4'b1000, '0, 1'b0);
    chk("emptypp_cnt",  128'(cnt(3)),  128'd1);
    chk("emptypp_head", 128'(stat(3)), 128'h33);

    // Fill and drain channel 0 six times, wrapping the pointers.
    irq_cnt = 0;
    irq_cnt_en = 1;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) push_w(0, DW'(32'h100 + r*16 + k));
      for (int k = 0; k < 4; k++) begin
        chk("wrap_head", 128'(stat(0)), 128'(32'h100 + r*16 + k));
        pop_m(4'b0001);
      end
      pop_m(4'b0001);
      chk("wrap_empty_cnt", 128'(cnt(0)), 128'd0);
    end
    irq_cnt_en = 0;
    chk("wrap_irq_pulses", 128'(irq_cnt), 128'd6);

    // Sustained push+pop on a non-empty channel.
    push_w(0, 32'h200);
    for (int k = 1; k <= 3; k++) cycle(1'b1, 0, DW'(32'h200 + k), 4'b0001, '0, 1'b0);
    chk("stream_cnt",  128'(cnt(0)),  128'd1);
    chk("stream_head", 128'(stat(0)), 128'h203);

    // Flush channel 2 holding 3 entries with overflow set, with a simultaneous push.
    for (int k = 0; k < 4; k++) push_w(2, DW'(32'h21 + k));
    pop_m(4'b0100);
    chk("clr_pre_cnt", 128'(cnt(2)), 128'd3);
    chk("clr_pre_ovf", 128'(ovf[2]), 128'd1);
    cycle(1'b1, 2, 32'h99, 4'b0100, 4'b0100, 1'b0);
    chk("clr_cnt",  128'(cnt(2)),     128'd0);
    chk("clr_vld",  128'(tsk_vld[2]), 128'd0);
    chk("clr_ovf",  128'(ovf[2]),     128'd0);
    chk("clr_stat", 128'(stat(2)),    128'd0);

    // Reset while every channel holds data.
    for (int c = 0; c < NCH; c++) push_w(c, DW'(32'h500 + c));
    cycle(1'b0, 0, '0, '0, '0, 1'b1);
    chk("mrst_stat", 128'(tsk_stat), 128'd0);
    chk("mrst_vld",  128'(tsk_vld),  128'd0);
    chk("mrst_cnt",  128'(tsk_cnt),  128'd0);
    chk("mrst_ovf",  128'(ovf),      128'd0);
    chk("mrst_irq",  128'(irq),      128'd0);
    push_w(1, 32'hBEEF);
    chk("post_vld",  128'(tsk_vld), 128'b0010);
    chk("post_irq",  128'(irq),     128'b0010);
    chk("post_stat", 128'(stat(1)), 128'hBEEF);
    pop_m('0);
    pop_m('0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
